// File: rtl/sram_arbiter_if.sv
// Bus bundle between two requesters, the SRAM arbiter and the SRAM macro.
// The arbiter connects through the slave modport; requesters and the SRAM model use the master modport.
interface sram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    req_valid;
  logic [1:0]    req_wr;
  logic [AW-1:0] req0_addr;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req0_wdata;
  logic [DW-1:0] req1_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;

  modport slave (
    input  req_valid, req_wr, req0_addr, req1_addr, req0_wdata, req1_wdata, rdata,
    output req_ready, rsp_valid, rsp_rdata, wr, rd, addr, wdata, busy
  );

  modport master (
    output req_valid, req_wr, req0_addr, req1_addr, req0_wdata, req1_wdata, rdata,
    input  req_ready, rsp_valid, rsp_rdata, wr, rd, addr, wdata, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter for a single-port SRAM with fixed read latency.
// One transaction in flight; all outputs are registered.
module sram_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // WAIT runs RD_LAT-1 cycles; the counter is loaded with one less than that.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t        state;
  logic          last;
  logic          winner;
  logic [1:0]    wait_cnt;
  logic          sram_wr;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [1:0]    ready;
  logic [1:0]    rsp_vld;
  logic [DW-1:0] rsp_data;
  logic          busy_reg;

  logic          grant_any;
  logic          grant_idx;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_idx = ~last;
      end
      default: begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
      end
    endcase
  end

  // Transaction FSM with registered SRAM strobes and requester handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      winner     <= 1'b0;
      wait_cnt   <= 2'd0;
      sram_wr    <= 1'b0;
      sram_rd    <= 1'b0;
      sram_addr  <= {AW{1'b0}};
      sram_wdata <= {DW{1'b0}};
      ready      <= 2'b00;
      rsp_vld    <= 2'b00;
      rsp_data   <= {DW{1'b0}};
      busy_reg   <= 1'b0;
    end else begin
      sram_wr <= 1'b0;
      sram_rd <= 1'b0;
      ready   <= 2'b00;
      rsp_vld <= 2'b00;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= ACCESS;
            busy_reg   <= 1'b1;
            winner     <= grant_idx;
            last       <= grant_idx;
            sram_addr  <= grant_idx ? bus.req1_addr : bus.req0_addr;
            sram_wdata <= grant_idx ? bus.req1_wdata : bus.req0_wdata;
            sram_wr    <= bus.req_wr[grant_idx];
            sram_rd    <= ~bus.req_wr[grant_idx];
            ready      <= grant_idx ? 2'b10 : 2'b01;
          end else begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end
        ACCESS: begin
          if (sram_wr) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end else if (RD_LAT <= 1) begin
            state <= CAPTURE;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        CAPTURE: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          rsp_data <= bus.rdata;
          rsp_vld  <= winner ? 2'b10 : 2'b01;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr        = sram_wr;
  assign bus.rd        = sram_rd;
  assign bus.addr      = sram_addr;
  assign bus.wdata     = sram_wdata;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_rdata = rsp_data;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: RD_LAT=1 and RD_LAT=3 instances, each with a behavioural SRAM.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(8), .DW(8)) b1 ();
  sram_arbiter_if #(.AW(8), .DW(8)) b3 ();

  sram_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  sram_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(b3));

  // SRAM models: data read in the rd cycle appears on rdata RD_LAT cycles later, zero otherwise.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  always @(posedge clk) begin
    if (b1.wr) mem1[b1.addr] <= b1.wdata;
    pipe1 <= b1.rd ? mem1[b1.addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (b3.wr) mem3[b3.addr] <= b3.wdata;
    pipe3[0] <= b3.rd ? mem3[b3.addr] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign b1.rdata = pipe1;
  assign b3.rdata = pipe3[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         grants;
  logic [1:0] seen;

  initial begin
    rst = 1'b0;
    b1.req_valid = 2'b00; b1.req_wr = 2'b00;
    b1.req0_addr = 8'h00; b1.req1_addr = 8'h00; b1.req0_wdata = 8'h00; b1.req1_wdata = 8'h00;
    b3.req_valid = 2'b00; b3.req_wr = 2'b00;
    b3.req0_addr = 8'h00; b3.req1_addr = 8'h00; b3.req0_wdata = 8'h00; b3.req1_wdata = 8'h00;
    tick(); tick();
    check_eq("rst_busy", 16'(b1.busy), 16'h0);
    check_eq("rst_wr_rd", 16'({b1.wr, b1.rd}), 16'h0);
    check_eq("rst_addr", 16'(b1.addr), 16'h00);
    check_eq("rst_rdata", 16'(b1.rsp_rdata), 16'h00);
    rst = 1'b1;
    tick();

    // Single write from requester 0.
    b1.req_valid = 2'b01; b1.req_wr = 2'b01; b1.req0_addr = 8'h10; b1.req0_wdata = 8'hA5;
    tick();
    check_eq("wr_strobe", 16'({b1.wr, b1.rd}), 16'h2);
    check_eq("wr_addr", 16'(b1.addr), 16'h10);
    check_eq("wr_wdata", 16'(b1.wdata), 16'hA5);
    check_eq("wr_ready", 16'(b1.req_ready), 16'h1);
    check_eq("wr_busy", 16'(b1.busy), 16'h1);
    b1.req_valid = 2'b00;
    tick();
    check_eq("wr_idle_busy", 16'(b1.busy), 16'h0);
    check_eq("wr_idle_strobe", 16'({b1.wr, b1.rd, b1.req_ready}), 16'h0);
    check_eq("addr_hold", 16'(b1.addr), 16'h10);

    // Read-back by requester 1, RD_LAT=1.
    b1.req_valid = 2'b10; b1.req_wr = 2'b00; b1.req1_addr = 8'h10;
    tick();
    check_eq("rd_strobe", 16'({b1.wr, b1.rd}), 16'h1);
    check_eq("rd_ready", 16'(b1.req_ready), 16'h2);
    b1.req_valid = 2'b00;
    tick();
    check_eq("rd_capture_busy", 16'(b1.busy), 16'h1);
    check_eq("rd_capture_rsp", 16'(b1.rsp_valid), 16'h0);
    tick();
    check_eq("rd_rsp_valid", 16'(b1.rsp_valid), 16'h2);
    check_eq("rd_rsp_rdata", 16'(b1.rsp_rdata), 16'hA5);
    check_eq("rd_rsp_busy", 16'(b1.busy), 16'h0);
    tick();
    check_eq("rsp_pulse_end", 16'(b1.rsp_valid), 16'h0);
    check_eq("rsp_rdata_hold", 16'(b1.rsp_rdata), 16'hA5);

    // Contention: both write continuously; grants must alternate 0,1,0,1.
    b1.req_valid = 2'b11; b1.req_wr = 2'b11;
    b1.req0_addr = 8'h20; b1.req0_wdata = 8'h3C;
    b1.req1_addr = 8'h21; b1.req1_wdata = 8'hC3;
    grants = 0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      tick();
      if (b1.req_ready != 2'b00) begin
        check_eq("rr_grant", 16'(b1.req_ready), (grants % 2 == 1) ? 16'h2 : 16'h1);
        check_eq("rr_addr", 16'(b1.addr), (grants % 2 == 1) ? 16'h21 : 16'h20);
        grants++;
        if (grants == 4) b1.req_valid = 2'b00;
      end
    end
    check_eq("rr_count", 16'(grants), 16'd4);
    tick();

    // Requester 0 reads what requester 1 wrote.
    b1.req_valid = 2'b01; b1.req_wr = 2'b00; b1.req0_addr = 8'h21;
    tick();
    check_eq("xrd_ready", 16'(b1.req_ready), 16'h1);
    b1.req_valid = 2'b00;
    tick(); tick();
    check_eq("xrd_rsp_valid", 16'(b1.rsp_valid), 16'h1);
    check_eq("xrd_rsp_rdata", 16'(b1.rsp_rdata), 16'hC3);

    // RD_LAT=3: write then read with the longer pipeline.
    b3.req_valid = 2'b01; b3.req_wr = 2'b01; b3.req0_addr = 8'h33; b3.req0_wdata = 8'h77;
    tick();
    b3.req_valid = 2'b00;
    tick();
    b3.req_valid = 2'b10; b3.req_wr = 2'b00; b3.req1_addr = 8'h33;
    tick();
    check_eq("l3_rd_strobe", 16'({b3.wr, b3.rd}), 16'h1);
    check_eq("l3_busy_t1", 16'(b3.busy), 16'h1);
    b3.req_valid = 2'b00;
    tick();
    check_eq("l3_busy_t2", 16'(b3.busy), 16'h1);
    tick();
    check_eq("l3_busy_t3", 16'(b3.busy), 16'h1);
    tick();
    check_eq("l3_busy_t4", 16'(b3.busy), 16'h1);
    check_eq("l3_rsp_early", 16'(b3.rsp_valid), 16'h0);
    tick();
    check_eq("l3_rsp_valid", 16'(b3.rsp_valid), 16'h2);
    check_eq("l3_rsp_rdata", 16'(b3.rsp_rdata), 16'h77);
    check_eq("l3_busy_t5", 16'(b3.busy), 16'h0);

    // Reset during WAIT aborts the read.
    b3.req_valid = 2'b01; b3.req_wr = 2'b00; b3.req0_addr = 8'h33;
    tick();
    check_eq("ab_rd", 16'(b3.rd), 16'h1);
    b3.req_valid = 2'b00;
    tick();
    #1;
    rst = 1'b0;
    #1;
    check_eq("ab_busy", 16'(b3.busy), 16'h0);
    check_eq("ab_strobes", 16'({b3.wr, b3.rd, b3.req_ready, b3.rsp_valid}), 16'h0);
    check_eq("ab_addr", 16'(b3.addr), 16'h00);
    check_eq("ab_rsp_rdata", 16'(b3.rsp_rdata), 16'h00);
    tick(); tick();
    rst = 1'b1;
    seen = 2'b00;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | b3.rsp_valid;
    end
    check_eq("ab_no_rsp", 16'(seen), 16'h0);
    b3.req_valid = 2'b11; b3.req_wr = 2'b00; b3.req0_addr = 8'h01; b3.req1_addr = 8'h02;
    tick();
    check_eq("ab_first_grant", 16'(b3.req_ready), 16'h1);
    b3.req_valid = 2'b00;
    tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
